// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: core/dmem handshake structs,
// arbiter FSM states and the latched request payload.
package dmem_arbiter_pkg;

  // Core -> memory request. valid/wen/byte_not_word/write_data form the request;
  // yumi is the requester consuming a response.
  typedef struct packed {
    logic [31:0] write_data;
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic        yumi;
  } mem_in_s;

  // Memory -> core response. yumi accepts a request; valid/read_data carry the reply.
  typedef struct packed {
    logic [31:0] read_data;
    logic        valid;
    logic        yumi;
  } mem_out_s;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  // Request fields captured at grant time and replayed to dmem until accepted.
  typedef struct packed {
    logic [31:0] write_data;
    logic        wen;
    logic        byte_not_word;
    logic [31:0] addr;
  } arb_payload_s;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Single data-memory port shared by the arbiter (master) and dmem (slave).
//
// Handshake (two-phase valid/yumi):
//   phase 1: master holds mem_req.valid with a stable payload; the request is
//            accepted in the cycle where slave raises mem_rsp.yumi.
//   phase 2: slave holds mem_rsp.valid/read_data; the response is consumed in
//            the cycle where master raises mem_req.yumi.
//   Both phases may complete in the same cycle.
interface dmem_arbiter_if;
  import dmem_arbiter_pkg::*;

  mem_in_s     mem_req;
  logic [31:0] mem_addr;
  mem_out_s    mem_rsp;

  modport master (output mem_req, output mem_addr, input mem_rsp);
  modport slave  (input mem_req, input mem_addr, output mem_rsp);
endinterface

// File: rtl/dmem_arbiter_rr_picker.sv
// Combinational round-robin priority: grants the first requester at or after
// ptr_i, wrapping to index 0 when nothing at or above the pointer requests.
module dmem_arbiter_rr_picker #(
  parameter int num_req_p = 4
) (
  input  logic [num_req_p-1:0]         req_i,
  input  logic [$clog2(num_req_p)-1:0] ptr_i,
  output logic [$clog2(num_req_p)-1:0] grant_o,
  output logic                         any_o
);
  localparam int idx_w_lp = $clog2(num_req_p);

  logic                hi_found;
  logic                lo_found;
  logic [idx_w_lp-1:0] hi_idx;
  logic [idx_w_lp-1:0] lo_idx;

  // Scan downward so the lowest index in each region is the one kept.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = num_req_p - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        lo_found = 1'b1;
        lo_idx   = idx_w_lp'(i);
        if (i >= int'(ptr_i)) begin
          hi_found = 1'b1;
          hi_idx   = idx_w_lp'(i);
        end
      end
    end
  end

  assign any_o   = lo_found;
  assign grant_o = hi_found ? hi_idx : lo_idx;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between num_cores_p cores, one transaction in
// flight, round-robin grant. Core-side handshake is passed through unchanged
// to the current owner; non-owners see an all-zero response.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int num_cores_p = 4,
  parameter int timeout_p   = 255
) (
  input  logic                           clk,
  input  logic                           reset,
  input  mem_in_s                        core_req_i  [num_cores_p],
  input  logic [31:0]                    core_addr_i [num_cores_p],
  output mem_out_s                       core_rsp_o  [num_cores_p],
  dmem_arbiter_if.master                 mem,
  output logic [$clog2(num_cores_p)-1:0] owner_o,
  output logic                           busy_o,
  output logic                           timeout_o,
  output arb_state_e                     state_o,
  output logic [$clog2(num_cores_p)-1:0] rr_ptr_o
);
  localparam int owner_w_lp = $clog2(num_cores_p);
  localparam int cnt_w_lp   = $clog2(timeout_p + 1);
  localparam logic [cnt_w_lp-1:0] cnt_max_lp = cnt_w_lp'(timeout_p);

  arb_state_e            state_q, state_d;
  arb_payload_s          payload_q;
  logic [owner_w_lp-1:0] owner_q, rr_ptr_q, rr_next, grant;
  logic [num_cores_p-1:0] req_vec;
  logic                  any_req;
  logic [cnt_w_lp-1:0]   wait_cnt_q;
  logic                  timeout_q;
  logic                  done;
  logic                  owner_yumi;
  logic                  fwd_yumi, fwd_valid;
  logic [31:0]           fwd_data;

  // Collect request valids for the picker.
  always_comb begin
    for (int k = 0; k < num_cores_p; k++) req_vec[k] = core_req_i[k].valid;
  end

  dmem_arbiter_rr_picker #(.num_req_p(num_cores_p)) u_picker (
    .req_i   (req_vec),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .any_o   (any_req)
  );

  assign owner_yumi = core_req_i[owner_q].yumi;
  assign rr_next    = (owner_q == owner_w_lp'(num_cores_p - 1)) ? '0 : owner_q + 1'b1;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ARB_IDLE;
    else       state_q <= state_d;
  end

  // Next state, dmem-side outputs and the response to forward to the owner.
  always_comb begin
    state_d      = state_q;
    done         = 1'b0;
    fwd_yumi     = 1'b0;
    fwd_valid    = 1'b0;
    fwd_data     = '0;
    mem.mem_req  = '0;
    mem.mem_addr = '0;
    case (state_q)
      ARB_IDLE: begin
        if (any_req) state_d = ARB_REQ;
      end
      ARB_REQ: begin
        mem.mem_req.valid         = 1'b1;
        mem.mem_req.write_data    = payload_q.write_data;
        mem.mem_req.wen           = payload_q.wen;
        mem.mem_req.byte_not_word = payload_q.byte_not_word;
        mem.mem_addr              = payload_q.addr;
        fwd_yumi                  = mem.mem_rsp.yumi;
        // dmem may accept and answer in the same cycle.
        if (mem.mem_rsp.yumi && mem.mem_rsp.valid) begin
          fwd_valid       = 1'b1;
          fwd_data        = mem.mem_rsp.read_data;
          mem.mem_req.yumi = owner_yumi;
          done            = owner_yumi;
        end
        if (done)                  state_d = ARB_IDLE;
        else if (mem.mem_rsp.yumi) state_d = ARB_RESP;
      end
      ARB_RESP: begin
        fwd_valid        = mem.mem_rsp.valid;
        fwd_data         = mem.mem_rsp.read_data;
        mem.mem_req.yumi = owner_yumi;
        done             = mem.mem_rsp.valid && owner_yumi;
        if (done) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Route the forwarded response to the owner only; everyone else sees zero.
  always_comb begin
    for (int j = 0; j < num_cores_p; j++) begin
      core_rsp_o[j] = '0;
      if (int'(owner_q) == j) begin
        core_rsp_o[j].yumi      = fwd_yumi;
        core_rsp_o[j].valid     = fwd_valid;
        core_rsp_o[j].read_data = fwd_data;
      end
    end
  end

  // Capture the winner's payload at grant; it is replayed even if the core drops valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      payload_q <= '0;
      owner_q   <= '0;
    end else if (state_q == ARB_IDLE && any_req) begin
      payload_q.write_data    <= core_req_i[grant].write_data;
      payload_q.wen           <= core_req_i[grant].wen;
      payload_q.byte_not_word <= core_req_i[grant].byte_not_word;
      payload_q.addr          <= core_addr_i[grant];
      owner_q                 <= grant;
    end
  end

  // Advance the round-robin pointer past the owner once its response is consumed.
  always_ff @(posedge clk) begin
    if (reset)     rr_ptr_q <= '0;
    else if (done) rr_ptr_q <= rr_next;
  end

  // Count response-wait cycles; the flag is sticky, the transaction keeps waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else if (state_q == ARB_REQ && mem.mem_rsp.yumi) begin
      wait_cnt_q <= '0;
    end else if (state_q == ARB_RESP && !done && wait_cnt_q != cnt_max_lp) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
      if (wait_cnt_q + 1'b1 == cnt_max_lp) timeout_q <= 1'b1;
    end
  end

  assign owner_o   = owner_q;
  assign busy_o    = (state_q != ARB_IDLE);
  assign timeout_o = timeout_q;
  assign state_o   = state_q;
  assign rr_ptr_o  = rr_ptr_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: the bench plays the four cores and dmem.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int n_lp = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_in_s     core_req  [n_lp];
  logic [31:0] core_addr [n_lp];
  mem_out_s    core_rsp  [n_lp];
  logic [1:0]  owner, rr_ptr;
  logic        busy, timeout;
  arb_state_e  state;

  dmem_arbiter_if mem_if ();

  dmem_arbiter #(.num_cores_p(n_lp), .timeout_p(255)) dut (
    .clk         (clk),
    .reset       (reset),
    .core_req_i  (core_req),
    .core_addr_i (core_addr),
    .core_rsp_o  (core_rsp),
    .mem         (mem_if),
    .owner_o     (owner),
    .busy_o      (busy),
    .timeout_o   (timeout),
    .state_o     (state),
    .rr_ptr_o    (rr_ptr)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input int except);
    for (int j = 0; j < n_lp; j++)
      if (j != except) check($sformatf("quiet_core%0d", j), core_rsp[j], 0);
  endtask

  // Called with the arbiter in REQ owned by core k: dmem accepts, idles one
  // RESP cycle, then answers with rdata while core k consumes it.
  task automatic run_txn(input int k, input logic [31:0] rdata);
    mem_if.mem_rsp.yumi = 1'b1;
    #1;
    check("req_fwd_yumi", core_rsp[k].yumi, 1);
    check("req_mem_valid", mem_if.mem_req.valid, 1);
    check_quiet(k);
    tick();
    mem_if.mem_rsp.yumi = 1'b0;
    core_req[k].valid = 1'b0;
    #1;
    check("resp_state", state, ARB_RESP);
    check("resp_req_quiet", mem_if.mem_req.valid, 0);
    check("resp_no_valid_yet", core_rsp[k].valid, 0);
    tick();
    mem_if.mem_rsp.valid = 1'b1;
    mem_if.mem_rsp.read_data = rdata;
    core_req[k].yumi = 1'b1;
    #1;
    check("resp_valid", core_rsp[k].valid, 1);
    check("resp_data", core_rsp[k].read_data, rdata);
    check("resp_mem_yumi", mem_if.mem_req.yumi, 1);
    check_quiet(k);
    tick();
    mem_if.mem_rsp.valid = 1'b0;
    mem_if.mem_rsp.read_data = '0;
    core_req[k].yumi = 1'b0;
    #1;
    check("done_idle", state, ARB_IDLE);
    check("done_busy", busy, 0);
  endtask

  task automatic set_req(input int k, input logic [31:0] addr, input logic wen, input logic [31:0] wd);
    core_req[k].valid = 1'b1;
    core_req[k].wen = wen;
    core_req[k].write_data = wd;
    core_req[k].byte_not_word = 1'b0;
    core_addr[k] = addr;
  endtask

  // Watchdog: the bench is cycle-exact, this only guards against a stuck clock.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    for (int k = 0; k < n_lp; k++) begin
      core_req[k] = '0;
      core_addr[k] = '0;
    end
    mem_if.mem_rsp = '0;
    tick();
    tick();
    check("rst_state", state, ARB_IDLE);
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    check("rst_timeout", timeout, 0);
    check("rst_rr_ptr", rr_ptr, 0);
    check("rst_mem_req", mem_if.mem_req, 0);
    check_quiet(-1);
    reset = 1'b0;
    tick();

    // All four cores request together; rr_ptr=0 gives 0,1,2,3.
    for (int k = 0; k < n_lp; k++) begin
      set_req(k, 32'h100 + 32'(k * 4), k[0], 32'hA000 + 32'(k));
      exp_q.push_back(32'(k));
    end
    for (int t = 0; t < n_lp; t++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      tick();
      check("rr_owner", owner, e);
      check("rr_addr", mem_if.mem_addr, 32'h100 + e * 4);
      check("rr_wen", mem_if.mem_req.wen, e[0]);
      check("rr_wdata", mem_if.mem_req.write_data, 32'hA000 + e);
      run_txn(int'(e), 32'hD000 + e);
    end
    check("rr_ptr_wrap", rr_ptr, 0);

    // Single core 0 LW at 0x10: dmem yumi in cycle 2, valid in cycle 4.
    set_req(0, 32'h10, 1'b0, 32'h0);
    tick();
    check("lw_busy", busy, 1);
    check("lw_owner", owner, 0);
    check("lw_addr", mem_if.mem_addr, 32'h10);
    check("lw_wen", mem_if.mem_req.wen, 0);
    check("lw_no_yumi", core_rsp[0].yumi, 0);
    tick();
    run_txn(0, 32'hCAFE_0010);
    check("lw_rr_ptr", rr_ptr, 1);
    check("lw_owner_hold", owner, 0);

    // Core 2 SW in flight; core 1 arrives and must wait. Core 2 also drops
    // valid early, the latched write is still issued.
    set_req(2, 32'h200, 1'b1, 32'h5A5A);
    tick();
    check("sw_owner", owner, 2);
    set_req(1, 32'h300, 1'b0, 32'h0);
    core_req[2].valid = 1'b0;
    #1;
    check("sw_hold_valid", mem_if.mem_req.valid, 1);
    check("sw_hold_wen", mem_if.mem_req.wen, 1);
    check("sw_hold_wdata", mem_if.mem_req.write_data, 32'h5A5A);
    check("sw_hold_addr", mem_if.mem_addr, 32'h200);
    run_txn(2, 32'h0);
    check("sw_rr_ptr", rr_ptr, 3);
    tick();
    check("wait_owner", owner, 1);
    check("wait_addr", mem_if.mem_addr, 32'h300);
    run_txn(1, 32'h1234_5678);
    check("wait_rr_ptr", rr_ptr, 2);

    // Same-cycle accept + answer with owner consuming: one REQ cycle only.
    set_req(3, 32'h40, 1'b0, 32'h0);
    tick();
    check("sc_owner", owner, 3);
    core_req[3].valid = 1'b0;
    core_req[3].yumi = 1'b1;
    mem_if.mem_rsp.yumi = 1'b1;
    mem_if.mem_rsp.valid = 1'b1;
    mem_if.mem_rsp.read_data = 32'hBEEF;
    #1;
    check("sc_yumi", core_rsp[3].yumi, 1);
    check("sc_valid", core_rsp[3].valid, 1);
    check("sc_data", core_rsp[3].read_data, 32'hBEEF);
    check("sc_mem_yumi", mem_if.mem_req.yumi, 1);
    tick();
    mem_if.mem_rsp = '0;
    core_req[3].yumi = 1'b0;
    #1;
    check("sc_idle", state, ARB_IDLE);
    check("sc_rr_ptr", rr_ptr, 0);

    // dmem withholds valid for 300 RESP cycles.
    set_req(1, 32'h80, 1'b0, 32'h0);
    tick();
    check("to_owner", owner, 1);
    mem_if.mem_rsp.yumi = 1'b1;
    tick();
    mem_if.mem_rsp.yumi = 1'b0;
    core_req[1].valid = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      tick();
      if (n == 254) check("to_before", timeout, 0);
      if (n == 255) check("to_set", timeout, 1);
    end
    check("to_sticky", timeout, 1);
    check("to_still_busy", state, ARB_RESP);
    mem_if.mem_rsp.valid = 1'b1;
    mem_if.mem_rsp.read_data = 32'h7777;
    core_req[1].yumi = 1'b1;
    #1;
    check("to_late_data", core_rsp[1].read_data, 32'h7777);
    tick();
    mem_if.mem_rsp = '0;
    core_req[1].yumi = 1'b0;
    #1;
    check("to_done_idle", state, ARB_IDLE);
    check("to_after", timeout, 1);
    check("to_rr_ptr", rr_ptr, 2);

    // Reset while waiting in RESP.
    set_req(3, 32'hC0, 1'b0, 32'h0);
    tick();
    check("rr3_owner", owner, 3);
    mem_if.mem_rsp.yumi = 1'b1;
    tick();
    mem_if.mem_rsp.yumi = 1'b0;
    check("rr3_resp", state, ARB_RESP);
    reset = 1'b1;
    tick();
    core_req[3].valid = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_mem_req", mem_if.mem_req, 0);
    check("mid_rst_rr_ptr", rr_ptr, 0);
    check("mid_rst_owner", owner, 0);
    check("mid_rst_timeout", timeout, 0);
    check_quiet(-1);
    reset = 1'b0;
    tick();
    check("post_rst_idle", state, ARB_IDLE);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
